// File: rtl/hsv_pixel_source.sv
// hsv_pixel_source
//
// Converts an RGB565 pixel stream into HSV for the ball colour classifier.
// Green is truncated to 5 bits so all three channels share a 0..31 scale.
// Each accepted pixel runs through a small FSM:
//   IDLE -> PREP (1 cycle) -> DIV (DIV_BITS cycles) -> EMIT (1 cycle) -> IDLE
// Two restoring dividers run side by side in DIV:
//   saturation = delta*31/mx and hue offset = |diff|*60/delta.
//
// Handshake: a pixel is taken on a rising edge where
//   pix_valid && pix_ready && href && !vsync.
// pix_ready is high only in IDLE. The producer holds r/g/b stable while
// pix_valid is high and pix_ready is low.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   vsync             frame sync; aborts the pixel in flight, clears column
//   href              line valid; column counter clears while low
//   pix_valid         r/g/b hold a pixel
//   pix_ready         block is in IDLE and can take a pixel
//   r[4:0] g[5:0] b[4:0]  RGB565 input pixel
//   hue[8:0]          0..359 degrees
//   saturation[4:0]   0..31
//   value[4:0]        0..31
//   write             one-cycle strobe, outputs valid in this cycle
//   horiz_count[9:0]  column of the emitted pixel within its line
//
// Optional feature macro: HSV_SRC_DARK_CLAMP_EN
//   When defined, pixels with max channel < 4 emit hue=0 and saturation=0.
//   The divider still runs, so latency is unchanged.

module hsv_pixel_source #(
  parameter int DIV_BITS = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vsync,
  input  logic       href,
  input  logic       pix_valid,
  output logic       pix_ready,
  input  logic [4:0] r,
  input  logic [5:0] g,
  input  logic [4:0] b,
  output logic [8:0] hue,
  output logic [4:0] saturation,
  output logic [4:0] value,
  output logic       write,
  output logic [9:0] horiz_count
);

  // Dividend needs 11 bits (31*60 = 1860); extra DIV_BITS of headroom hold
  // the divisor pre-shifted to its top quotient position.
  localparam int CW    = 11 + DIV_BITS;
  localparam int CNT_W = $clog2(DIV_BITS + 1);

  localparam logic [1:0] SEC_R = 2'd0;
  localparam logic [1:0] SEC_G = 2'd1;
  localparam logic [1:0] SEC_B = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PREP = 2'd1,
    S_DIV  = 2'd2,
    S_EMIT = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [4:0]          r_q, r_d, g5_q, g5_d, b_q, b_d;
  logic [9:0]          col_q, col_d;
  logic [9:0]          pix_col_q, pix_col_d;
  logic [4:0]          mx_q, mx_d;
  logic [1:0]          sector_q, sector_d;
  logic                neg_q, neg_d;
  logic                mx_zero_q, mx_zero_d;
  logic                delta_zero_q, delta_zero_d;
  logic [CW-1:0]       rem_s_q, rem_s_d, dsh_s_q, dsh_s_d;
  logic [CW-1:0]       rem_h_q, rem_h_d, dsh_h_q, dsh_h_d;
  logic [DIV_BITS-1:0] quo_s_q, quo_s_d, quo_h_q, quo_h_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [8:0]          hue_q, hue_d;
  logic [4:0]          sat_q, sat_d;
  logic [4:0]          val_q, val_d;
  logic                write_q, write_d;
  logic [9:0]          hcount_q, hcount_d;

  logic       accept;
  logic [4:0] mx_c, mn_c, delta_c, abs_diff_c;
  logic [1:0] sector_c;
  logic       neg_c;
  logic [8:0] qh9, hue_c, base_c;
  logic [4:0] qs5, sat_c;
  logic       g_lsb_unused;

  // Green LSB is dropped by the 5-bit truncation.
  assign g_lsb_unused = g[0];

  assign pix_ready   = (state_q == S_IDLE);
  assign accept      = pix_ready && pix_valid && href && !vsync;
  assign hue         = hue_q;
  assign saturation  = sat_q;
  assign value       = val_q;
  assign write       = write_q;
  assign horiz_count = hcount_q;

  // Max/min/sector of the captured pixel; ties resolve r, then g, then b.
  always_comb begin
    mx_c       = r_q;
    mn_c       = r_q;
    sector_c   = SEC_R;
    abs_diff_c = '0;
    neg_c      = 1'b0;
    if (g5_q > mx_c) mx_c = g5_q;
    if (b_q  > mx_c) mx_c = b_q;
    if (g5_q < mn_c) mn_c = g5_q;
    if (b_q  < mn_c) mn_c = b_q;
    if (r_q >= g5_q && r_q >= b_q) begin
      sector_c = SEC_R;
      if (g5_q >= b_q) abs_diff_c = g5_q - b_q;
      else begin abs_diff_c = b_q - g5_q; neg_c = 1'b1; end
    end else if (g5_q >= b_q) begin
      sector_c = SEC_G;
      if (b_q >= r_q) abs_diff_c = b_q - r_q;
      else begin abs_diff_c = r_q - b_q; neg_c = 1'b1; end
    end else begin
      sector_c = SEC_B;
      if (r_q >= g5_q) abs_diff_c = r_q - g5_q;
      else begin abs_diff_c = g5_q - r_q; neg_c = 1'b1; end
    end
    delta_c = mx_c - mn_c;
  end

  // Final hue/saturation from the finished quotients.
  always_comb begin
    qh9 = 9'(quo_h_q);
    qs5 = 5'(quo_s_q);
    case (sector_q)
      SEC_G:   base_c = 9'd120;
      SEC_B:   base_c = 9'd240;
      default: base_c = 9'd0;
    endcase
    if (delta_zero_q)          hue_c = 9'd0;
    else if (!neg_q)           hue_c = base_c + qh9;
    else if (sector_q == SEC_R) hue_c = 9'd360 - qh9;
    else                       hue_c = base_c - qh9;
    sat_c = mx_zero_q ? 5'd0 : qs5;
`ifdef HSV_SRC_DARK_CLAMP_EN
    if (mx_q < 5'd4) begin
      hue_c = 9'd0;
      sat_c = 5'd0;
    end
`endif
  end

  // Column counter: clears outside a line or on frame sync, saturates at 1023.
  always_comb begin
    col_d = col_q;
    if (!href || vsync)                 col_d = '0;
    else if (accept && col_q != 10'd1023) col_d = col_q + 10'd1;
  end

  always_comb begin
    state_d      = state_q;
    r_d          = r_q;
    g5_d         = g5_q;
    b_d          = b_q;
    pix_col_d    = pix_col_q;
    mx_d         = mx_q;
    sector_d     = sector_q;
    neg_d        = neg_q;
    mx_zero_d    = mx_zero_q;
    delta_zero_d = delta_zero_q;
    rem_s_d      = rem_s_q;
    dsh_s_d      = dsh_s_q;
    rem_h_d      = rem_h_q;
    dsh_h_d      = dsh_h_q;
    quo_s_d      = quo_s_q;
    quo_h_d      = quo_h_q;
    cnt_d        = cnt_q;
    hue_d        = hue_q;
    sat_d        = sat_q;
    val_d        = val_q;
    hcount_d     = hcount_q;
    write_d      = 1'b0;

    if (vsync && state_q != S_IDLE) begin
      // Frame sync drops the pixel in flight without a strobe.
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            r_d       = r;
            g5_d      = g[5:1];
            b_d       = b;
            pix_col_d = col_q;
            state_d   = S_PREP;
          end
        end
        S_PREP: begin
          mx_d         = mx_c;
          sector_d     = sector_c;
          neg_d        = neg_c;
          mx_zero_d    = (mx_c == 5'd0);
          delta_zero_d = (delta_c == 5'd0);
          rem_s_d      = CW'(delta_c) * CW'(5'd31);
          dsh_s_d      = CW'(mx_c) << (DIV_BITS - 1);
          rem_h_d      = CW'(abs_diff_c) * CW'(6'd60);
          dsh_h_d      = CW'(delta_c) << (DIV_BITS - 1);
          quo_s_d      = '0;
          quo_h_d      = '0;
          cnt_d        = '0;
          state_d      = S_DIV;
        end
        S_DIV: begin
          // One quotient bit per cycle, MSB first; divisor shifts right.
          // A zero divisor yields garbage here, masked by the zero flags.
          if (rem_s_q >= dsh_s_q) begin
            rem_s_d = rem_s_q - dsh_s_q;
            quo_s_d = (quo_s_q << 1) | DIV_BITS'(1);
          end else begin
            quo_s_d = quo_s_q << 1;
          end
          if (rem_h_q >= dsh_h_q) begin
            rem_h_d = rem_h_q - dsh_h_q;
            quo_h_d = (quo_h_q << 1) | DIV_BITS'(1);
          end else begin
            quo_h_d = quo_h_q << 1;
          end
          dsh_s_d = dsh_s_q >> 1;
          dsh_h_d = dsh_h_q >> 1;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DIV_BITS - 1)) state_d = S_EMIT;
        end
        S_EMIT: begin
          hue_d    = hue_c;
          sat_d    = sat_c;
          val_d    = mx_q;
          hcount_d = pix_col_q;
          write_d  = 1'b1;
          state_d  = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      r_q          <= '0;
      g5_q         <= '0;
      b_q          <= '0;
      col_q        <= '0;
      pix_col_q    <= '0;
      mx_q         <= '0;
      sector_q     <= SEC_R;
      neg_q        <= 1'b0;
      mx_zero_q    <= 1'b0;
      delta_zero_q <= 1'b0;
      rem_s_q      <= '0;
      dsh_s_q      <= '0;
      rem_h_q      <= '0;
      dsh_h_q      <= '0;
      quo_s_q      <= '0;
      quo_h_q      <= '0;
      cnt_q        <= '0;
      hue_q        <= '0;
      sat_q        <= '0;
      val_q        <= '0;
      write_q      <= 1'b0;
      hcount_q     <= '0;
    end else begin
      state_q      <= state_d;
      r_q          <= r_d;
      g5_q         <= g5_d;
      b_q          <= b_d;
      col_q        <= col_d;
      pix_col_q    <= pix_col_d;
      mx_q         <= mx_d;
      sector_q     <= sector_d;
      neg_q        <= neg_d;
      mx_zero_q    <= mx_zero_d;
      delta_zero_q <= delta_zero_d;
      rem_s_q      <= rem_s_d;
      dsh_s_q      <= dsh_s_d;
      rem_h_q      <= rem_h_d;
      dsh_h_q      <= dsh_h_d;
      quo_s_q      <= quo_s_d;
      quo_h_q      <= quo_h_d;
      cnt_q        <= cnt_d;
      hue_q        <= hue_d;
      sat_q        <= sat_d;
      val_q        <= val_d;
      write_q      <= write_d;
      hcount_q     <= hcount_d;
    end
  end

endmodule

// File: doc/hsv_pixel_source.md
# hsv_pixel_source

Converts the camera's RGB565 pixel stream into the HSV pixel stream consumed by the ball colour classifier. Each output pixel carries a one-cycle `write` strobe and the pixel's column index (`horiz_count`). It sits between the camera capture front end and the classifier and drives that classifier's `hue`/`saturation`/`value`/`write`/`horiz_count` inputs directly. Conversion uses an iterative divider with a fixed latency; input is flow-controlled by a valid/ready handshake.

## Interface
- `DIV_BITS`, default 6: quotient width of the iterative divider. This is also the number of divide cycles.
- `clk`  in  1  system clock. All logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `vsync`  in  1  frame sync, active high. Aborts the pixel in flight and clears the column counter.
- `href`  in  1  line valid. Pixels are accepted only while high; the column counter clears while low.
- `pix_valid`  in  1  `r`/`g`/`b` hold a pixel.
- `pix_ready`  out  1  block can accept a pixel; high only in IDLE.
- `r`  in  5  red. `g` in 6 green. `b` in 5 blue.
- `hue`  out  9  0..359 degrees.
- `saturation`  out  5  0..31.
- `value`  out  5  0..31.
- `write`  out  1  one-cycle strobe; `hue`/`saturation`/`value`/`horiz_count` are valid in this cycle.
- `horiz_count`  out  10  column index of the emitted pixel within its line.

## Operation
- Accept: a pixel is accepted on a rising edge where `pix_valid && pix_ready && href && !vsync`.
  - `r`, `g[5:1]` (green truncated to 5 bits) and `b` are registered, together with the current column counter value.
  - The column counter then increments. It saturates at 1023 and clears to 0 whenever `href`=0 or `vsync`=1.
- State machine: IDLE → PREP (1 cycle) → DIV (`DIV_BITS` cycles) → EMIT (1 cycle) → IDLE.
- PREP:
  - mx = max(r,g5,b), mn = min(r,g5,b), delta = mx−mn.
  - Sector tie priority is r, then g, then b.
  - Sector r: diff = g5−b, base 0. Sector g: diff = b−r, base 120. Sector b: diff = r−g5, base 240.
- DIV: two restoring dividers run in parallel.
  - Saturation: qs = (delta·31)/mx.
  - Hue: qh = (|diff|·60)/delta.
  - Both quotients truncate.
  - If mx=0, qs=0. If delta=0, qh=0 and hue=0.
- EMIT: drive outputs from registers with `write`=1.
  - value = mx.
  - saturation = qs.
  - hue = base+qh if diff≥0, otherwise base−qh. In sector r with diff<0, hue = 360−qh.
  - Hue range is 0..359 by construction; 360 is never produced.
- Outputs hold their last values between strobes; only `write` returns to 0.
- `vsync`=1 in any non-IDLE state: next state is IDLE, no `write`, outputs unchanged.
- `pix_valid` while `href`=0: not accepted, and the column counter does not advance.

## Timing
- Reset values: `hue`=0, `saturation`=0, `value`=0, `horiz_count`=0, `write`=0, `pix_ready`=1 (IDLE). The column counter resets to 0.
- Reset asserted mid-conversion drops the pixel immediately with no `write`.
- Latency: acceptance at edge T gives `write`=1 in the cycle after edge T+`DIV_BITS`+2 (8 cycles with the default).
- Throughput: one pixel per `DIV_BITS`+3 cycles. `pix_ready` is low from PREP through EMIT and high again in the cycle after EMIT.
- `horiz_count` at EMIT is the column captured at acceptance. A line ending (`href` falling) mid-conversion does not alter it.
- `vsync` and acceptance on the same edge: vsync wins and nothing is accepted.

## Configuration
- Macro: `HSV_SRC_DARK_CLAMP_EN`.
- Defined: if mx<4, EMIT forces hue=0 and saturation=0. The divider still runs, so latency is unchanged.
- Undefined: dark pixels are converted normally. For example r=3,g=0,b=0 gives hue 0, sat 31, val 3.

## Test plan
- Primaries, one at a time with `href`=1:
  - r=31,g=0,b=0 → hue 0, sat 31, val 31, `write` 8 cycles after accept.
  - g=63 → hue 120.
  - b=31 → hue 240.
- Negative red sector: r=31,g=0,b=15 → hue 331, sat 31, val 31.
- Grey and black:
  - r=16,g=32,b=16 → hue 0, sat 0, val 16.
  - All zero → hue 0, sat 0, val 0 with no divide fault.
- Column tracking:
  - Pixels held continuously valid over 3 accepts → `horiz_count` 0,1,2.
  - Then `href` low then high, next pixel → 0.
  - `pix_ready` pattern is 1 then 0 for 8 cycles, repeating with period 9.
- Abort: `vsync` pulsed during DIV → no `write`, `pix_ready`=1 next cycle, the next pixel's `horiz_count`=0.
- Async reset mid-DIV → all outputs 0 immediately. With `HSV_SRC_DARK_CLAMP_EN` defined, r=3,g=0,b=0 → sat 0, hue 0, val 3.
